// File: rtl/rcs_seq_sub.sv
`default_nettype none
// ============================================================================
//  Module   : rcs_seq_sub
//  Purpose  : Multi-cycle ripple-borrow subtractor. Computes a - b one
//             SLICE-bit stage per clock, LSB first, with the borrow held in
//             a flop between slices. Valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module rcs_seq_sub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             brw;
    logic [IW-1:0]    idx;
    logic             last_slice;
    int               base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   sum;

    // Current slice operands and the one shared subtract stage.
    // Subtraction is a + ~b + 1 with the incoming borrow folded into the carry-in.
    always_comb begin
        base       = int'(idx) * SLICE;
        a_sl       = a_q[base +: SLICE];
        b_sl       = b_q[base +: SLICE];
        sum        = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, ~brw};
        last_slice = (idx == IW'(NSL - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; no bypass from DONE straight into a new accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = CALC;
            CALC:    if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one slice of result per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            brw    <= 1'b0;
            idx    <= '0;
        end else if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
            brw <= 1'b0;
            idx <= '0;
        end else if (state == CALC) begin
            diff_q[base +: SLICE] <= sum[SLICE-1:0];
            brw                   <= ~sum[SLICE];
            idx                   <= idx + IW'(1);
        end
    end

    // Outputs come only from registers and state decode.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        diff      = diff_q;
        bout      = brw;
        ovf       = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
    end

endmodule
`default_nettype wire

// File: doc/rcs_seq_sub.md
# rcs_seq_sub

Multi-cycle ripple-borrow subtractor, the subtract-side companion to the team's 32-bit ripple-carry adder. It computes `diff = a - b` by reusing one `SLICE`-bit subtract stage, processing one slice per clock from LSB to MSB with the borrow held in a register between slices. Operands enter and results leave through valid/ready handshakes, so the block drops into datapaths where adder area matters more than latency.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; must be an integer multiple of `SLICE`.
- `SLICE`, 8: bits processed per cycle. `NSL = WIDTH/SLICE` is the slice count.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands on `a`/`b` are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  minuend, unsigned or two's complement.
- `b`  in  WIDTH  subtrahend.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  downstream accepts the result.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `bout`  out  1  borrow out; 1 iff `a < b` unsigned.
- `ovf`  out  1  signed overflow: `a[W-1] != b[W-1]` and `diff[W-1] != a[W-1]`.

## Operation
- FSM states: IDLE, CALC, DONE. Registers: `a_q`, `b_q`, `diff_q`, borrow flop `brw`, slice counter `idx` of width `clog2(NSL)`.
- In IDLE, `in_ready=1`. When `in_valid & in_ready` is sampled on an edge (accept), the block captures `a`, `b` into `a_q`, `b_q`, clears `brw` and `idx`, and moves to CALC.
- CALC, at each edge, processes slice `idx`:
  - `{c, s} = a_q[idx] + ~b_q[idx] + ~brw` (SLICE+1 bits).
  - `diff_q[idx] <= s`, `brw <= ~c`, `idx <= idx+1`.
  - On the edge where `idx == NSL-1`, the FSM moves to DONE. `bout` is the final `brw`.
- `ovf` is decoded combinationally from `a_q[W-1]`, `b_q[W-1]`, `diff_q[W-1]`. It is meaningful only while `out_valid=1`.
- DONE: `out_valid=1`, and `diff`, `bout`, `ovf` are held stable. When `out_ready` is sampled high, the FSM returns to IDLE.
- `in_ready` is low in CALC and DONE. The block does not bypass: a new accept cannot happen on the same edge as the output handshake.
- `a` and `b` are ignored outside the accept edge. Changes during CALC or DONE do not affect the result.
- `out_ready` is ignored outside DONE.
- Reset, asserted at any time including mid-CALC or during DONE:
  - FSM goes to IDLE, `idx=0`, `brw=0`, `diff_q=0`, `a_q=b_q=0`.
  - The in-flight operation is discarded and no result is produced for it.

## Timing
- Output reset values: `in_ready=1` (decoded from IDLE), `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`. No transfer happens while `rst_n=0`.
- Latency: if accept is on edge E0, CALC runs on edges E1..E`NSL`. `out_valid` goes high after edge E`NSL`, which is 4 cycles for the defaults.
- Minimum initiation interval is `NSL+2` cycles (6 for the defaults): accept, NSL slices, output handshake.
- With `out_ready` held high, `out_valid` stays high for exactly one cycle per result.
- While `out_ready` is low, `out_valid` stays high and outputs do not change for any number of cycles.
- All outputs come from registers or from FSM-state decode. There is no combinational path from any input to any output.

## Test plan
- `a=0x00000005`, `b=0x00000003`, `out_ready=1` -> `out_valid` high exactly 4 cycles after accept, with `diff=0x00000002`, `bout=0`, `ovf=0`.
- `a=0x00000000`, `b=0x00000001` (borrow ripples through all slices) -> `diff=0xFFFFFFFF`, `bout=1`, `ovf=0`. Also `a=0x7FFFFFFF`, `b=0xFFFFFFFF` -> `diff=0x80000000`, `bout=1`, `ovf=1`.
- `a=0x80000000`, `b=0x00000001` -> `diff=0x7FFFFFFF`, `bout=0`, `ovf=1`. Also `a=b=0xDEADBEEF` -> `diff=0`, `bout=0`, `ovf=0`.
- Backpressure: `out_ready=0` for 5 cycles after `out_valid` rises -> `diff`, `bout`, `ovf` stable, `in_ready=0`. After `out_ready=1` for one edge, `out_valid=0` and `in_ready=1` on the next cycle. Throughout, `a`/`b` are changed every cycle to check that the result is unaffected.
- Reset mid-op: pulse `rst_n` low asynchronously (between edges) while `idx=2` -> `out_valid=0` and `in_ready=1` immediately, with `diff=0`. A following op `0x00010000 - 0x00000001` returns `0x0000FFFF`, `bout=0`.
- Back-to-back: hold `in_valid=1` and `out_ready=1`, and feed 100 random operand pairs -> each result equals a reference model of `a-b`, `a<b`, and the signed-overflow rule. Exactly one accept occurs every 6 cycles.
